// File: rtl/mem_sp_param_if.sv
// Request/response bundle for the parametrised single-port memory.
// The master drives requests; the slave (the memory) returns read data and status.
interface mem_sp_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wr_enable;
    logic              rd_enable;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              busy;
    logic              drop_err;

    modport master (
        output wr_enable, rd_enable, addr, data_in,
        input  data_out, rd_valid, busy, drop_err
    );

    modport slave (
        input  wr_enable, rd_enable, addr, data_in,
        output data_out, rd_valid, busy, drop_err
    );
endinterface

// File: rtl/mem_sp_param.sv
// Parametrised single-port memory: registered reads with RD_LAT-deep pipeline,
// read-valid strobe, optional zero-fill after reset with busy/drop reporting.
module mem_sp_param #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int RD_LAT     = 1,
    parameter int CLR_ON_RST = 1
) (
    input  logic           clk,
    input  logic           rst,
    mem_sp_param_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("mem_sp_param: RD_LAT must be in 1..4");
    end
    if (DATA_W < 1 || DATA_W > 64) begin : g_bad_width
        $error("mem_sp_param: DATA_W must be in 1..64");
    end

    typedef enum logic [0:0] {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t                          state;
    logic [ADDR_W-1:0]               clr_ptr;
    logic                            busy_reg;
    logic                            drop_reg;

    logic [DATA_W-1:0]               mem [DEPTH];
    logic                            mem_we;
    logic [ADDR_W-1:0]               mem_wa;
    logic [DATA_W-1:0]               mem_wd;
    logic                            rd_acc;

    logic [RD_LAT-1:0]               vld_pipe;
    logic [RD_LAT-1:0][DATA_W-1:0]   dat_pipe;
    logic [DATA_W-1:0]               dout_reg;
    logic                            rvld_reg;

    // Clear/ready sequencer; busy and drop_err are registered alongside the state.
    // busy falls on the same edge that writes the last word, so it reads high
    // for exactly DEPTH cycles after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= (CLR_ON_RST != 0) ? CLEAR : READY;
            busy_reg <= (CLR_ON_RST != 0);
            clr_ptr  <= '0;
            drop_reg <= 1'b0;
        end else begin
            drop_reg <= busy_reg && (bus.rd_enable || bus.wr_enable);
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == {ADDR_W{1'b1}}) begin
                        state    <= READY;
                        busy_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Single write port shared by the clear sweep and user writes.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = bus.addr;
        mem_wd = bus.data_in;
        if (!rst) begin
            if (state == CLEAR) begin
                mem_we = 1'b1;
                mem_wa = clr_ptr;
                mem_wd = '0;
            end else if (bus.wr_enable) begin
                mem_we = 1'b1;
            end
        end
    end

    assign rd_acc = !rst && (state == READY) && bus.rd_enable;

    // Storage array; no reset so it maps onto RAM. Same-edge read sees old data.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Read pipeline: stage 0 samples the array on the request edge, the output
    // register updates RD_LAT edges later. Reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
            dout_reg <= '0;
            rvld_reg <= 1'b0;
        end else begin
            vld_pipe[0] <= rd_acc;
            if (rd_acc) begin
                dat_pipe[0] <= mem[bus.addr];
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
            rvld_reg <= vld_pipe[RD_LAT-1];
            if (vld_pipe[RD_LAT-1]) begin
                dout_reg <= dat_pipe[RD_LAT-1];
            end
        end
    end

    assign bus.data_out = dout_reg;
    assign bus.rd_valid = rvld_reg;
    assign bus.busy     = busy_reg;
    assign bus.drop_err = drop_reg;
endmodule

// File: tb/tb_mem_sp_param.sv
// Bench for mem_sp_param: default instance checked against a queue-based
// reference model plus a vector table, and a wide/deep RD_LAT=3 instance
// exercised with hand-written sequences.
module tb_mem_sp_param;
    logic clk;
    logic rst_a;
    logic rst_b;

    mem_sp_param_if #(.DATA_W(8),  .ADDR_W(4)) bus_a ();
    mem_sp_param_if #(.DATA_W(32), .ADDR_W(6)) bus_b ();

    mem_sp_param #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1), .CLR_ON_RST(1)) dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a)
    );
    mem_sp_param #(.DATA_W(32), .ADDR_W(6), .RD_LAT(3), .CLR_ON_RST(1)) dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model for instance A: words, remaining clear cycles, and a
    // queue of reads tagged with the cycle their result is due.
    typedef struct { int due; logic [7:0] d; } rd_t;
    rd_t        rq[$];
    logic [7:0] m_mem [16];
    int         m_clr  = 0;
    logic       m_drop = 1'b0;
    logic       m_v    = 1'b0;
    logic [7:0] m_dout = 8'h00;
    int         cyc    = 0;

    task automatic model_edge(input logic r, input logic w, input logic rd,
                              input logic [3:0] ad, input logic [7:0] d);
        cyc++;
        m_v = 1'b0;
        if (r) begin
            rq.delete();
            m_dout = 8'h00;
            m_drop = 1'b0;
            m_clr  = 16;
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        end else begin
            m_drop = (m_clr > 0) && (w || rd);
            if (m_clr > 0) begin
                m_clr--;
            end else begin
                if (rd) rq.push_back('{cyc + 1, m_mem[ad]});
                if (w)  m_mem[ad] = d;
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                m_v    = 1'b1;
                m_dout = rq[0].d;
                void'(rq.pop_front());
            end
        end
    endtask

    task automatic step_a(input logic r, input logic w, input logic rd,
                          input int ad, input logic [7:0] d);
        logic [3:0] a4;
        a4 = ad[3:0];
        @(negedge clk);
        rst_a = r; bus_a.wr_enable = w; bus_a.rd_enable = rd;
        bus_a.addr = a4; bus_a.data_in = d;
        @(posedge clk);
        model_edge(r, w, rd, a4, d);
        #1;
        chk("a_rd_valid", bus_a.rd_valid, m_v);
        chk("a_data_out", bus_a.data_out, m_dout);
        chk("a_busy",     bus_a.busy,     m_clr > 0);
        chk("a_drop_err", bus_a.drop_err, m_drop);
    endtask

    task automatic step_b(input logic r, input logic w, input logic rd,
                          input logic [5:0] ad, input logic [31:0] d);
        @(negedge clk);
        rst_b = r; bus_b.wr_enable = w; bus_b.rd_enable = rd;
        bus_b.addr = ad; bus_b.data_in = d;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       w;
        logic       rd;
        int         ad;
        logic [7:0] din;
        logic       ev;
        logic [7:0] ed;
    } vec_t;

    initial begin
        vec_t tbl [10];
        int   cnt;
        int   drops;

        // Outputs expected after each row's edge (RD_LAT=1, data holds when idle).
        tbl[0] = '{1'b1, 1'b0,  3, 8'hA5, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 1'b0, 12, 8'h5A, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 1'b1,  3, 8'h00, 1'b0, 8'h00};
        tbl[3] = '{1'b0, 1'b1, 12, 8'h00, 1'b1, 8'hA5};
        tbl[4] = '{1'b0, 1'b0,  0, 8'h00, 1'b1, 8'h5A};
        tbl[5] = '{1'b1, 1'b0,  7, 8'h11, 1'b0, 8'h5A};
        tbl[6] = '{1'b1, 1'b1,  7, 8'h22, 1'b0, 8'h5A};
        tbl[7] = '{1'b0, 1'b1,  7, 8'h00, 1'b1, 8'h11};
        tbl[8] = '{1'b0, 1'b0,  0, 8'h00, 1'b1, 8'h22};
        tbl[9] = '{1'b0, 1'b0,  0, 8'h00, 1'b0, 8'h22};

        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.wr_enable = 1'b0; bus_a.rd_enable = 1'b0; bus_a.addr = '0; bus_a.data_in = '0;
        bus_b.wr_enable = 1'b0; bus_b.rd_enable = 1'b0; bus_b.addr = '0; bus_b.data_in = '0;

        // Clear phase with a dropped write to addr 15 along the way.
        step_a(1, 0, 0, 0, 8'h00);
        step_a(1, 0, 0, 0, 8'h00);
        chk("a_reset_dout", bus_a.data_out, 8'h00);
        chk("a_reset_valid", bus_a.rd_valid, 1'b0);
        cnt   = bus_a.busy ? 1 : 0;
        drops = 0;
        for (int k = 0; k < 40 && bus_a.busy; k++) begin
            step_a(0, k == 3, 0, 15, 8'hFF);
            if (bus_a.busy) cnt++;
            if (bus_a.drop_err) drops++;
        end
        chk("a_busy_len", cnt, 16);
        chk("a_drop_pulses", drops, 1);

        // Every word reads back zero, one per cycle, latency 1.
        for (int i = 0; i <= 16; i++) begin
            step_a(0, 0, i < 16, i, 8'h00);
            if (i > 0) begin
                chk("a_clr_valid", bus_a.rd_valid, 1'b1);
                chk("a_clr_data", bus_a.data_out, 8'h00);
            end
        end

        // Basic write/read and same-address collision.
        for (int i = 0; i < 10; i++) begin
            step_a(0, tbl[i].w, tbl[i].rd, tbl[i].ad, tbl[i].din);
            chk("tbl_valid", bus_a.rd_valid, tbl[i].ev);
            chk("tbl_data",  bus_a.data_out, tbl[i].ed);
        end

        // Random traffic with occasional resets against the model.
        for (int i = 0; i < 400; i++) begin
            step_a($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
                   8'($urandom_range(0, 255)));
        end

        // Reset at clear cycle 8 restarts the full clear.
        step_a(1, 0, 0, 0, 8'h00);
        for (int k = 0; k < 7; k++) step_a(0, 0, 0, 0, 8'h00);
        chk("a_midclr_busy", bus_a.busy, 1'b1);
        step_a(1, 0, 0, 0, 8'h00);
        cnt = bus_a.busy ? 1 : 0;
        for (int k = 0; k < 40 && bus_a.busy; k++) begin
            step_a(0, 0, 0, 0, 8'h00);
            if (bus_a.busy) cnt++;
        end
        chk("a_midclr_len", cnt, 16);

        // Wide/deep instance, RD_LAT=3.
        step_b(1, 0, 0, 6'd0, 32'h0);
        step_b(1, 0, 0, 6'd0, 32'h0);
        cnt = bus_b.busy ? 1 : 0;
        for (int k = 0; k < 200 && bus_b.busy; k++) begin
            step_b(0, 0, 0, 6'd0, 32'h0);
            if (bus_b.busy) cnt++;
        end
        chk("b_busy_len", cnt, 64);
        step_b(0, 1, 0, 6'd63, 32'hDEADBEEF);
        step_b(0, 0, 1, 6'd63, 32'h0);
        chk("b_lat_v0", bus_b.rd_valid, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step_b(0, 0, 0, 6'd0, 32'h0);
            chk("b_lat_valid", bus_b.rd_valid, k == 3);
            if (k >= 3) chk("b_lat_data", bus_b.data_out, 32'hDEADBEEF);
        end

        // Reset one cycle after a read: the read never completes.
        step_b(0, 1, 0, 6'd5, 32'h12345678);
        step_b(0, 0, 1, 6'd5, 32'h0);
        step_b(1, 0, 0, 6'd0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            chk("b_rst_valid", bus_b.rd_valid, 1'b0);
            chk("b_rst_data",  bus_b.data_out, 32'h0);
            step_b(0, 0, 0, 6'd0, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
